// File: rtl/othello_pkg.sv
// rtl/othello_pkg.sv - shared board constants, cell codes and requester ids
package othello_pkg;

    localparam int BOARD_W = 10;
    localparam int CELLS   = 100;

    localparam logic [1:0] CELL_EMPTY  = 2'b00;
    localparam logic [1:0] CELL_BLACK  = 2'b01;
    localparam logic [1:0] CELL_WHITE  = 2'b10;
    localparam logic [1:0] CELL_BORDER = 2'b11;

    // Address deltas for walking the bordered board one cell per step
    localparam int STEP_N = -10;
    localparam int STEP_S = 10;
    localparam int STEP_W = -1;
    localparam int STEP_E = 1;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_FLIP = 2'd1,
        REQ_VALI = 2'd2,
        REQ_DISP = 2'd3
    } req_id_t;

endpackage

// File: rtl/starve_counter.sv
// rtl/starve_counter.sv - saturating starvation counter with clear and at_limit flag
module starve_counter #(
    parameter int LIMIT = 8,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clear,
    output logic at_limit
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != LIM)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign at_limit = (cnt == LIM);

endmodule

// File: rtl/board_mem_arbiter.sv
// rtl/board_mem_arbiter.sv - fixed-priority board RAM arbiter with display anti-starvation
module board_mem_arbiter #(
    parameter int ADDR_W       = 7,
    parameter int DATA_W       = 2,
    parameter int CELLS        = othello_pkg::CELLS,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flip_req_i,
    input  logic              flip_we_i,
    input  logic [ADDR_W-1:0] flip_addr_i,
    input  logic [DATA_W-1:0] flip_wdata_i,
    output logic              flip_gnt_o,
    output logic              flip_rvalid_o,
    input  logic              vali_req_i,
    input  logic [ADDR_W-1:0] vali_addr_i,
    output logic              vali_gnt_o,
    output logic              vali_rvalid_o,
    input  logic              disp_req_i,
    input  logic [ADDR_W-1:0] disp_addr_i,
    output logic              disp_gnt_o,
    output logic              disp_rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              oob_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    import othello_pkg::*;

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_W:0] CELLS_L = CELLS[ADDR_W:0];

    req_id_t           sel;
    req_id_t           owner_q;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_read;
    logic              in_range;
    logic              at_limit;
    logic              oob_q;

    always_comb begin
        sel = REQ_NONE;
        if (reset) begin
            sel = REQ_NONE;
        end else if (at_limit && disp_req_i) begin
            sel = REQ_DISP;
        end else if (flip_req_i) begin
            sel = REQ_FLIP;
        end else if (vali_req_i) begin
            sel = REQ_VALI;
        end else if (disp_req_i) begin
            sel = REQ_DISP;
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_read = 1'b0;
        case (sel)
            REQ_FLIP: begin
                sel_addr = flip_addr_i;
                sel_read = !flip_we_i;
            end
            REQ_VALI: begin
                sel_addr = vali_addr_i;
                sel_read = 1'b1;
            end
            REQ_DISP: begin
                sel_addr = disp_addr_i;
                sel_read = 1'b1;
            end
            default: ;
        endcase
    end

    assign in_range    = ({1'b0, sel_addr} < CELLS_L);
    assign flip_gnt_o  = (sel == REQ_FLIP);
    assign vali_gnt_o  = (sel == REQ_VALI);
    assign disp_gnt_o  = (sel == REQ_DISP);
    assign mem_addr_o  = sel_addr;
    assign mem_we_o    = flip_gnt_o && flip_we_i && in_range;
    assign mem_wdata_o = flip_gnt_o ? flip_wdata_i : '0;

    starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .W     (CNT_W)
    ) u_starve (
        .clock    (clock),
        .reset    (reset),
        .inc      (disp_req_i && !disp_gnt_o),
        .clear    (!disp_req_i || disp_gnt_o),
        .at_limit (at_limit)
    );

    // Owner tag remembers who gets the RAM output next cycle; writes leave it NONE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q <= REQ_NONE;
            oob_q   <= 1'b0;
        end else begin
            owner_q <= sel_read ? sel : REQ_NONE;
            oob_q   <= (sel != REQ_NONE) && !in_range;
        end
    end

    assign flip_rvalid_o = (owner_q == REQ_FLIP);
    assign vali_rvalid_o = (owner_q == REQ_VALI);
    assign disp_rvalid_o = (owner_q == REQ_DISP);
    assign oob_o         = oob_q;

    // Out-of-range reads return the border code instead of whatever the RAM aliased to
    always_comb begin
        rdata_o = '0;
        if (owner_q != REQ_NONE) begin
            rdata_o = oob_q ? {DATA_W{1'b1}} : mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// tb/tb_board_mem_arbiter.sv - scoreboard bench for board_mem_arbiter
module tb_board_mem_arbiter;

    localparam int LIMIT = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       flip_req_i = 1'b0, flip_we_i = 1'b0;
    logic [6:0] flip_addr_i = '0;
    logic [1:0] flip_wdata_i = '0;
    logic       vali_req_i = 1'b0;
    logic [6:0] vali_addr_i = '0;
    logic       disp_req_i = 1'b0;
    logic [6:0] disp_addr_i = '0;
    logic       flip_gnt_o, flip_rvalid_o, vali_gnt_o, vali_rvalid_o;
    logic       disp_gnt_o, disp_rvalid_o, oob_o, mem_we_o;
    logic [1:0] rdata_o, mem_wdata_o;
    logic [6:0] mem_addr_o;
    logic [1:0] mem_rdata_i;

    board_mem_arbiter dut (
        .clock(clock), .reset(reset),
        .flip_req_i(flip_req_i), .flip_we_i(flip_we_i), .flip_addr_i(flip_addr_i),
        .flip_wdata_i(flip_wdata_i), .flip_gnt_o(flip_gnt_o), .flip_rvalid_o(flip_rvalid_o),
        .vali_req_i(vali_req_i), .vali_addr_i(vali_addr_i), .vali_gnt_o(vali_gnt_o),
        .vali_rvalid_o(vali_rvalid_o),
        .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i), .disp_gnt_o(disp_gnt_o),
        .disp_rvalid_o(disp_rvalid_o),
        .rdata_o(rdata_o), .oob_o(oob_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clock = ~clock;

    function automatic logic [1:0] init_val(input int i);
        return 2'((i * 7 + i / 3) % 4);
    endfunction

    // Board RAM stand-in: synchronous read, one cycle latency
    logic [1:0] ram [0:127];
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) ram[i] <= init_val(i);
        end else if (mem_we_o) begin
            ram[mem_addr_o] <= mem_wdata_o;
        end
        mem_rdata_i <= ram[mem_addr_o];
    end

    typedef struct {
        int         id;
        logic [1:0] data;
        logic       oob;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] ref_mem [0:127];
    int         m_starve = 0;
    int         last_gnt = 0;
    logic       disp_seen = 1'b0;
    logic       do_reset_pulse = 1'b0;
    int         ntests = 0;
    int         nfail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] onehot(input int id);
        return {id == 1, id == 2, id == 3};
    endfunction

    // Reference model: who should own the RAM this cycle and what comes back next cycle
    task automatic model_cycle();
        int         id;
        logic [6:0] addr;
        logic       inr, is_wr;
        exp_t       rec;
        id = 0;
        if (reset) id = 0;
        else if (disp_req_i && m_starve == LIMIT) id = 3;
        else if (flip_req_i) id = 1;
        else if (vali_req_i) id = 2;
        else if (disp_req_i) id = 3;
        addr  = (id == 1) ? flip_addr_i : (id == 2) ? vali_addr_i : (id == 3) ? disp_addr_i : 7'd0;
        inr   = addr < 100;
        is_wr = (id == 1) && flip_we_i;
        check("gnt", {flip_gnt_o, vali_gnt_o, disp_gnt_o}, onehot(id));
        check("mem_we", mem_we_o, is_wr && inr);
        if (id != 0 || reset) check("mem_addr", mem_addr_o, addr);
        if (is_wr && inr) check("mem_wdata", mem_wdata_o, flip_wdata_i);
        rec.id   = (id != 0 && !is_wr) ? id : 0;
        rec.data = inr ? ref_mem[addr] : 2'b11;
        rec.oob  = (id != 0) && !inr;
        if (reset) begin
            for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
        end else if (is_wr && inr) begin
            ref_mem[addr] = flip_wdata_i;
        end
        if (reset || !disp_req_i || id == 3) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
        last_gnt  = id;
        disp_seen = disp_gnt_o;
        sb.push_back(rec);
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (do_reset_pulse) begin
                check("pre_reset_gnt", {flip_gnt_o, vali_gnt_o, disp_gnt_o}, 3'b010);
                reset = 1'b1;
                do_reset_pulse = 1'b0;
                #1;
            end
            model_cycle();
        end
    end

    initial begin
        exp_t rec;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                rec = sb.pop_front();
                check("rvalid", {flip_rvalid_o, vali_rvalid_o, disp_rvalid_o}, onehot(rec.id));
                check("oob", oob_o, rec.oob);
                if (rec.id != 0) check("rdata", rdata_o, rec.data);
                else if (reset) check("rdata_rst", rdata_o, 2'b00);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
        if (last_gnt == 1) flip_req_i = 1'b0;
        if (last_gnt == 2) vali_req_i = 1'b0;
        if (last_gnt == 3) disp_req_i = 1'b0;
    endtask

    function automatic logic [6:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return 7'($urandom_range(100, 127));
        return 7'($urandom_range(0, 99));
    endfunction

    // Display and validator both requesting; display must win on the (LIMIT+1)th cycle
    task automatic starve_run(input string name);
        int n = 0;
        bit got = 0;
        while (n < 20 && !got) begin
            tick();
            n++;
            got = disp_seen;
            if (!got) begin
                vali_req_i  = 1'b1;
                vali_addr_i = rand_addr();
            end
        end
        check(name, n, LIMIT + 1);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
        flip_req_i = 1'b1; vali_req_i = 1'b1; disp_req_i = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
        flip_req_i = 1'b0; vali_req_i = 1'b0; disp_req_i = 1'b0;
        tick();

        flip_req_i = 1'b1; flip_we_i = 1'b1; flip_addr_i = 7'd23; flip_wdata_i = 2'b01;
        tick();
        flip_req_i = 1'b1; flip_we_i = 1'b0; flip_addr_i = 7'd23;
        tick();
        tick();

        flip_req_i = 1'b1; flip_we_i = 1'b0; flip_addr_i = 7'd34;
        vali_req_i = 1'b1; vali_addr_i = 7'd45;
        repeat (3) tick();

        disp_req_i = 1'b1; disp_addr_i = 7'd55;
        vali_req_i = 1'b1; vali_addr_i = 7'd12;
        starve_run("starve_first");
        disp_req_i = 1'b1;
        vali_req_i = 1'b1;
        starve_run("starve_again");
        vali_req_i = 1'b0;
        tick();

        vali_req_i = 1'b1; vali_addr_i = 7'd100;
        repeat (2) tick();
        flip_req_i = 1'b1; flip_we_i = 1'b1; flip_addr_i = 7'd120; flip_wdata_i = 2'b10;
        repeat (2) tick();

        for (int c = 0; c < 400; c++) begin
            tick();
            if (!flip_req_i && $urandom_range(0, 2) == 0) begin
                flip_req_i = 1'b1; flip_we_i = 1'($urandom);
                flip_addr_i = rand_addr(); flip_wdata_i = 2'($urandom);
            end
            if (!vali_req_i && $urandom_range(0, 2) == 0) begin
                vali_req_i = 1'b1; vali_addr_i = rand_addr();
            end
            if (!disp_req_i && $urandom_range(0, 1) == 0) begin
                disp_req_i = 1'b1; disp_addr_i = rand_addr();
            end
        end
        flip_req_i = 1'b0; vali_req_i = 1'b0; disp_req_i = 1'b0;
        tick();

        disp_req_i = 1'b1; disp_addr_i = 7'd66;
        vali_req_i = 1'b1; vali_addr_i = 7'd44;
        repeat (3) begin
            tick();
            vali_req_i = 1'b1;
        end
        do_reset_pulse = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vali_req_i = 1'b1;
        starve_run("starve_after_reset");
        flip_req_i = 1'b0; vali_req_i = 1'b0; disp_req_i = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/board_mem_arbiter.md
Name: board_mem_arbiter

Overview:
Shares the single-port board RAM (10x10 bordered board, 100 cells, 2-bit cell codes) between three requesters: flipper (read/write), validator (read) and VGA display scanner (read). Fixed priority, anti-starvation for the display, 1-cycle read-data return and out-of-range protection. Sits between the move-sequencing datapath units and the board RAM.

Parameters:
ADDR_W, 7, cell address width
DATA_W, 2, cell code width (00 empty, 01 black, 10 white, 11 border)
CELLS, 100, number of valid addresses (0..CELLS-1)
STARVE_LIMIT, 8, consecutive denied display cycles before the display is forced to win

Ports:
clock  in  1  system clock (CLOCK_50)
reset  in  1  asynchronous, active-high reset
flip_req_i  in  1  flipper request, held until granted
flip_we_i  in  1  flipper write enable (1 write, 0 read)
flip_addr_i  in  ADDR_W  flipper address
flip_wdata_i  in  DATA_W  flipper write data
flip_gnt_o  out  1  flipper grant (combinational, same cycle)
flip_rvalid_o  out  1  flipper read data valid
vali_req_i  in  1  validator read request
vali_addr_i  in  ADDR_W  validator address
vali_gnt_o  out  1  validator grant
vali_rvalid_o  out  1  validator read data valid
disp_req_i  in  1  display read request
disp_addr_i  in  ADDR_W  display address
disp_gnt_o  out  1  display grant
disp_rvalid_o  out  1  display read data valid
rdata_o  out  DATA_W  shared read data, qualified by the *_rvalid_o strobes
oob_o  out  1  one-cycle pulse: a granted access had addr >= CELLS
mem_addr_o  out  ADDR_W  RAM address
mem_we_o  out  1  RAM write enable
mem_wdata_o  out  DATA_W  RAM write data
mem_rdata_i  in  DATA_W  RAM read data, valid 1 cycle after address

Behaviour:
- Reset (async, active-high): all gnt, rvalid, oob_o, mem_we_o = 0; mem_addr_o, mem_wdata_o, rdata_o = 0; starve counter = 0; owner tag = NONE. While reset is high, grants are forced low.
- Arbitration each cycle, combinational from req inputs plus registered starve counter: at most one gnt high.
- Priority: if starve_cnt == STARVE_LIMIT and disp_req_i, display wins; else flipper > validator > display.
- Granted requester drives mem_addr_o; mem_we_o = flip_we_i only when flipper is granted and address is in range; otherwise 0.
- Requester drops or changes req/addr only after its gnt cycle; one access per gnt cycle. Back-to-back grants to the same requester are allowed.
- Read return: in the cycle after a granted read, exactly one *_rvalid_o pulses for one cycle (registered owner tag) and rdata_o = mem_rdata_i. Writes produce no rvalid.
- Out-of-range (addr >= CELLS): grant is still issued, mem_we_o forced 0, oob_o pulses in the cycle after the grant. For reads, rvalid still pulses and rdata_o = 2'b11 (border), not RAM data.
- Starve counter: increments (saturating at STARVE_LIMIT) each cycle disp_req_i is high and disp_gnt_o is low; clears to 0 on disp grant or when disp_req_i is low.
- No grant in a cycle: owner tag = NONE, no rvalid next cycle.
- Reset mid-access: pending rvalid is discarded; no rvalid pulses after reset deasserts until a new grant.

Decomposition:
- Shared package othello_pkg: cell codes CELL_EMPTY/BLACK/WHITE/BORDER, BOARD_W = 10, CELLS = 100, direction step constants (-10, +10, -1, +1), requester ID encoding (NONE, FLIP, VALI, DISP).
- One sub-module: starve_counter (saturating counter with inc/clear and at_limit output).

Test Plan:
- Flipper only, write addr 23 data 01, then read addr 23 -> gnt same cycle both times, mem_we_o = 1 on the write only, flip_rvalid_o one cycle after the read with rdata_o = 01.
- flip_req and vali_req both high, addr 34 and 45 -> flip_gnt first; vali_gnt next cycle; flip_rvalid then vali_rvalid on consecutive cycles, correct data each.
- disp_req held high with vali_req continuously high -> display granted on the cycle after 8 denials; starve counter returns to 0 after that grant.
- vali read addr 100 -> gnt issued, mem_we_o = 0, next cycle vali_rvalid_o = 1, rdata_o = 11, oob_o = 1.
- Flipper write to addr 120 -> mem_we_o stays 0, oob_o pulses, no rvalid.
- Assert reset in the cycle a read is granted -> outputs reset immediately; no rvalid after reset drops; starve counter = 0.
